bound_flasher_monitor: RTL and testbench

- Receive-side checker/decoder for the flasher LED bar: samples the 16-bit thermometer-coded LED bus every clock and decodes it into a lit-LED level.
- Tracks sweep direction, reports peaks, troughs and completed full sweeps, and flags illegal patterns and illegal steps.
- Sits downstream of the flasher's LED output, in both system and bench builds, as the self-checking consumer of that interface.

---
 rtl/bound_flasher_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_bound_flasher_monitor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_monitor.sv
// Receive-side checker for the thermometer-coded flasher LED bar.
// Optional stall detector enabled by defining BOUND_MON_STALL_CHECK_EN.
module bound_flasher_monitor #(
   parameter int WIDTH     = 16,
   parameter int LVL_W     = 5,
   parameter int CNT_W     = 8,
   parameter int STALL_MAX = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] led_in,
   input  logic             err_clr,
   output logic [LVL_W-1:0] level,
   output logic [1:0]       dir,
   output logic             peak_evt,
   output logic [LVL_W-1:0] peak_level,
   output logic             trough_evt,
   output logic [LVL_W-1:0] trough_level,
   output logic             restart_evt,
   output logic             done_evt,
   output logic [CNT_W-1:0] done_count,
   output logic             err_illegal,
   output logic             err_jump,
   output logic             err_sticky,
   output logic             stall_err
);

   if ((2**LVL_W) <= WIDTH || STALL_MAX < 1) begin : g_cfg_bad
      $error("bound_flasher_monitor: bad parameters");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_UP   = 2'b01,
      S_DOWN = 2'b10,
      S_ERR  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic [LVL_W-1:0] peak_q, peak_d;
   logic [LVL_W-1:0] trough_q, trough_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic             pk_q, pk_d;
   logic             tr_q, tr_d;
   logic             rs_q, rs_d;
   logic             dn_q, dn_d;
   logic             ei_q, ei_d;
   logic             ej_q, ej_d;
   logic             stall_hit;

   logic [WIDTH-1:0] led_p1;
   logic             legal;
   logic [LVL_W-1:0] new_lvl;
   logic [LVL_W:0]   new_x, lvl_x;
   logic             step_up, step_dn, step_0;

   // A thermometer code plus one has no bits in common with itself.
   assign led_p1 = led_in + WIDTH'(1);
   assign legal  = ~|(led_in & led_p1);

   // Count lit LEDs; only meaningful when the pattern is legal.
   always_comb begin
      new_lvl = '0;
      for (int i = 0; i < WIDTH; i++) begin
         new_lvl = new_lvl + LVL_W'(led_in[i]);
      end
   end

   assign new_x   = {1'b0, new_lvl};
   assign lvl_x   = {1'b0, level_q};
   assign step_up = (new_x == lvl_x + 1'b1);
   assign step_dn = (new_x + 1'b1 == lvl_x);
   assign step_0  = (new_x == lvl_x);

`ifdef BOUND_MON_STALL_CHECK_EN
   localparam int SW = $clog2(STALL_MAX + 1);

   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic          stall_q;

   // Count consecutive no-change cycles while a sweep is in progress.
   always_comb begin
      stall_cnt_d = '0;
      stall_hit   = 1'b0;
      if (legal && step_0 &&
          (state_q == S_UP || state_q == S_DOWN)) begin
         if (stall_cnt_q == SW'(STALL_MAX - 1)) begin
            stall_hit = 1'b1;
         end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   // Stall counter and its registered pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         stall_q     <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_q     <= stall_hit;
      end
   end

   assign stall_err = stall_q;
`else
   assign stall_hit = 1'b0;
   assign stall_err = 1'b0;
`endif

   // Next-state, event and error decisions in priority order.
   always_comb begin
      state_d  = state_q;
      level_d  = legal ? new_lvl : level_q;
      full_d   = full_q;
      peak_d   = peak_q;
      trough_d = trough_q;
      cnt_d    = cnt_q;
      pk_d     = 1'b0;
      tr_d     = 1'b0;
      rs_d     = 1'b0;
      dn_d     = 1'b0;
      ei_d     = 1'b0;
      ej_d     = 1'b0;
      if (!legal) begin
         ei_d    = 1'b1;
         state_d = S_ERR;
      end else if (state_q == S_ERR) begin
         if (new_lvl == '0) begin
            state_d = S_IDLE;
         end
      end else if (new_lvl == '0 && level_q >= LVL_W'(2)) begin
         rs_d    = 1'b1;
         state_d = S_IDLE;
         full_d  = 1'b0;
      end else if (step_up) begin
         state_d = S_UP;
         if (state_q == S_DOWN) begin
            tr_d     = 1'b1;
            trough_d = level_q;
         end
         if (new_lvl == LVL_W'(WIDTH)) begin
            full_d = 1'b1;
         end
      end else if (step_dn) begin
         if (new_lvl == '0) begin
            state_d = S_IDLE;
            if (full_q) begin
               dn_d   = 1'b1;
               full_d = 1'b0;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end else begin
            state_d = S_DOWN;
            if (state_q == S_UP) begin
               pk_d   = 1'b1;
               peak_d = level_q;
            end
         end
      end else if (step_0) begin
         if (stall_hit) begin
            state_d = S_ERR;
         end
      end else begin
         ej_d    = 1'b1;
         state_d = S_ERR;
      end
      sticky_d = (sticky_q & ~err_clr) | ei_d | ej_d | stall_hit;
   end

   // Architectural state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         level_q  <= '0;
         full_q   <= 1'b0;
         peak_q   <= '0;
         trough_q <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         pk_q     <= 1'b0;
         tr_q     <= 1'b0;
         rs_q     <= 1'b0;
         dn_q     <= 1'b0;
         ei_q     <= 1'b0;
         ej_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         full_q   <= full_d;
         peak_q   <= peak_d;
         trough_q <= trough_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         pk_q     <= pk_d;
         tr_q     <= tr_d;
         rs_q     <= rs_d;
         dn_q     <= dn_d;
         ei_q     <= ei_d;
         ej_q     <= ej_d;
      end
   end

   assign level        = level_q;
   assign dir          = state_q;
   assign peak_evt     = pk_q;
   assign peak_level   = peak_q;
   assign trough_evt   = tr_q;
   assign trough_level = trough_q;
   assign restart_evt  = rs_q;
   assign done_evt     = dn_q;
   assign done_count   = cnt_q;
   assign err_illegal  = ei_q;
   assign err_jump     = ej_q;
   assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Bench for bound_flasher_monitor: directed LED sequences checked
// against an arithmetic model every cycle plus literal spot checks.
module tb_bound_flasher_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] led_in = '0;
   logic        err_clr = 1'b0;
   logic [4:0]  level;
   logic [1:0]  dir;
   logic        peak_evt;
   logic [4:0]  peak_level;
   logic        trough_evt;
   logic [4:0]  trough_level;
   logic        restart_evt;
   logic        done_evt;
   logic [7:0]  done_count;
   logic        err_illegal;
   logic        err_jump;
   logic        err_sticky;
   logic        stall_err;

   int nvec = 0;
   int nmis = 0;
   bit chk_en = 1'b0;

   bound_flasher_monitor dut (
      .clk(clk), .reset(reset), .led_in(led_in), .err_clr(err_clr),
      .level(level), .dir(dir),
      .peak_evt(peak_evt), .peak_level(peak_level),
      .trough_evt(trough_evt), .trough_level(trough_level),
      .restart_evt(restart_evt), .done_evt(done_evt),
      .done_count(done_count), .err_illegal(err_illegal),
      .err_jump(err_jump), .err_sticky(err_sticky),
      .stall_err(stall_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lvl; int st; int full; int peak; int trough;
      int cnt; int sticky; int sc;
      bit pk; bit tr; bit rs; bit dn; bit ei; bit ej; bit se;
   } mdl_t;

   mdl_t m = '{default: 0};

   // Model: st is 0 idle, 1 rising, 2 falling, 3 error.
   function automatic mdl_t mstep(mdl_t c, logic [15:0] led, logic clr);
      mdl_t r;
      int n, d;
      bit ok;
      r = c;
      r.pk = 0; r.tr = 0; r.rs = 0; r.dn = 0;
      r.ei = 0; r.ej = 0; r.se = 0;
      n  = $countones(led);
      ok = (int'(led) == (1 << n) - 1);
      d  = n - c.lvl;
      if (!ok) begin
         r.ei = 1; r.st = 3;
      end else if (c.st == 3) begin
         if (n == 0) r.st = 0;
      end else if (n == 0 && c.lvl >= 2) begin
         r.rs = 1; r.st = 0; r.full = 0;
      end else if (d == 1) begin
         r.st = 1;
         if (c.st == 2) begin r.tr = 1; r.trough = c.lvl; end
         if (n == 16) r.full = 1;
      end else if (d == -1) begin
         if (n == 0) begin
            r.st = 0;
            if (c.full != 0) begin
               r.dn = 1; r.full = 0;
               r.cnt = (c.cnt < 255) ? c.cnt + 1 : 255;
            end
         end else begin
            r.st = 2;
            if (c.st == 1) begin r.pk = 1; r.peak = c.lvl; end
         end
      end else if (d != 0) begin
         r.ej = 1; r.st = 3;
      end
`ifdef BOUND_MON_STALL_CHECK_EN
      if (ok && d == 0 && (c.st == 1 || c.st == 2)) begin
         r.sc = c.sc + 1;
         if (r.sc == 8) begin r.se = 1; r.st = 3; r.sc = 0; end
      end else begin
         r.sc = 0;
      end
`endif
      if (ok) r.lvl = n;
      if (clr) r.sticky = 0;
      if (r.ei || r.ej || r.se) r.sticky = 1;
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= '{default: 0};
      else m <= mstep(m, led_in, err_clr);
   end

   task automatic chk(input string nm, input int act, input int exp);
      if (act != exp) begin
         nmis++;
         $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic lit(input string nm, input int act, input int exp);
      nvec++;
      chk(nm, act, exp);
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (!reset && chk_en) begin
         nvec++;
         chk("level", level, m.lvl);
         chk("dir", dir, m.st);
         chk("peak_evt", peak_evt, m.pk);
         chk("peak_level", peak_level, m.peak);
         chk("trough_evt", trough_evt, m.tr);
         chk("trough_level", trough_level, m.trough);
         chk("restart_evt", restart_evt, m.rs);
         chk("done_evt", done_evt, m.dn);
         chk("done_count", done_count, m.cnt);
         chk("err_illegal", err_illegal, m.ei);
         chk("err_jump", err_jump, m.ej);
         chk("err_sticky", err_sticky, m.sticky);
         chk("stall_err", stall_err, m.se);
      end
   end

   function automatic logic [15:0] th(input int k);
      return 16'((32'd1 << k) - 1);
   endfunction

   task automatic step(input logic [15:0] v, input logic clr = 1'b0);
      @(negedge clk);
      led_in  = v;
      err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic ramp(input int a, input int b);
      if (a <= b) for (int k = a; k <= b; k++) step(th(k));
      else for (int k = a; k >= b; k--) step(th(k));
   endtask

   task automatic sweep();
      ramp(1, 16);
      ramp(15, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      lit("rst_level", level, 0);
      lit("rst_dir", dir, 0);
      lit("rst_done_count", done_count, 0);
      reset = 1'b0;
      chk_en = 1'b1;

      ramp(1, 5);
      lit("t1_level5", level, 5);
      lit("t1_dir_up", dir, 1);
      step(16'h000F);
      lit("t1_peak_evt", peak_evt, 1);
      lit("t1_peak_level", peak_level, 5);
      lit("t1_dir_down", dir, 2);
      ramp(3, 0);
      lit("t1_no_done", done_count, 0);

      sweep();
      lit("t2_done_evt", done_evt, 1);
      lit("t2_done_count", done_count, 1);
      lit("t2_dir_idle", dir, 0);

      ramp(1, 10);
      ramp(9, 5);
      step(th(6));
      lit("t3_trough_evt", trough_evt, 1);
      lit("t3_trough_level", trough_level, 5);
      lit("t3_peak_level", peak_level, 10);
      ramp(7, 9);
      step(16'h0000);
      lit("t5_restart_evt", restart_evt, 1);
      lit("t5_no_err", err_sticky, 0);
      lit("t5_done_same", done_count, 1);

      ramp(1, 2);
      step(16'h0005);
      lit("t4_err_illegal", err_illegal, 1);
      lit("t4_dir_err", dir, 3);
      lit("t4_sticky", err_sticky, 1);
      step(16'h0003);
      lit("t4_still_err", dir, 3);
      step(16'h0000);
      lit("t4_resync", dir, 0);
      step(16'h0000, 1'b1);
      lit("t4_clr", err_sticky, 0);

      ramp(1, 3);
      step(16'h001F);
      lit("t5_err_jump", err_jump, 1);
      step(16'h0000);
      step(16'h0000, 1'b1);

      step(16'h0005, 1'b1);
      lit("err_beats_clr", err_sticky, 1);
      step(16'h0000);
      step(16'h0000, 1'b1);

`ifdef BOUND_MON_STALL_CHECK_EN
      ramp(1, 4);
      repeat (7) step(th(4));
      lit("stall_quiet", stall_err, 0);
      step(th(4));
      lit("stall_err", stall_err, 1);
      lit("stall_dir", dir, 3);
      step(16'h0000);
      step(16'h0000, 1'b1);
`else
      ramp(1, 4);
      repeat (10) step(th(4));
      lit("nostall_dir", dir, 1);
      lit("nostall_err", stall_err, 0);
      step(16'h0000);
`endif

      repeat (254) sweep();
      lit("sat_count", done_count, 255);
      sweep();
      lit("sat_hold", done_count, 255);
      lit("sat_evt", done_evt, 1);

      ramp(1, 12);
      lit("pre_rst_level", level, 12);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      lit("arst_level", level, 0);
      lit("arst_dir", dir, 0);
      lit("arst_peak", peak_level, 0);
      lit("arst_done", done_count, 0);
      lit("arst_sticky", err_sticky, 0);
      led_in = '0;
      @(negedge clk);
      reset = 1'b0;
      step(th(1));
      lit("post_rst_level", level, 1);
      lit("post_rst_dir", dir, 1);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
